// File: rtl/fp_add_pipe_if.sv
// Operand/result streaming bundle for the pipelined fp adder.
// Master drives operands and result ready; slave is the adder.
interface fp_add_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic [3:0]   out_flags;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/fp_add_pipe.sv
// 3-stage streaming fp add/sub: unpack, align+add, normalise+round.
// RNE rounding, FTZ on inputs and outputs, canonical qNaN.
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic         clk,
  input  logic         reset,
  fp_add_pipe_if.slave bus
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int MW  = MAN_W + 1;
  localparam int AW  = MAN_W + 4;
  localparam int SW  = MAN_W + 5;
  localparam int LZW = $clog2(SW) + 1;
  localparam int EW  = (EXP_W + 2 > LZW + 1) ?
                       EXP_W + 2 : LZW + 1;

  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN =
    {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [EW-1:0] EMX =
    EW'(2**EXP_W - 1);

  logic adv;
  logic out_v;
  logic [W-1:0] out_r;
  logic [3:0] out_f;

  assign adv = ~out_v | bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = out_v;
  assign bus.out_result = out_r;
  assign bus.out_flags = out_f;

  // ---------------- stage 1
  logic sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb, fa_z, fb_z;
  logic za, zb, ia, ib, na, nb, a_big;

  assign sa = bus.in_a[W-1];
  assign sb = bus.in_b[W-1] ^ bus.in_op;
  assign ea = bus.in_a[W-2:MAN_W];
  assign eb = bus.in_b[W-2:MAN_W];
  assign fa = bus.in_a[MAN_W-1:0];
  assign fb = bus.in_b[MAN_W-1:0];

  assign za = (ea == '0);
  assign zb = (eb == '0);
  assign ia = (ea == EMAX) & (fa == '0);
  assign ib = (eb == EMAX) & (fb == '0);
  assign na = (ea == EMAX) & (fa != '0);
  assign nb = (eb == EMAX) & (fb != '0);

  assign fa_z = za ? '0 : fa;
  assign fb_z = zb ? '0 : fb;
  assign a_big = {ea, fa_z} >= {eb, fb_z};

  logic sp_hit, sp_inv;
  logic [W-1:0] sp_res;

  always_comb begin
    sp_hit = 1'b1;
    sp_inv = 1'b0;
    sp_res = QNAN;
    if (na | nb)
      sp_res = QNAN;
    else if (ia & ib & (sa ^ sb))
      sp_inv = 1'b1;
    else if (ia)
      sp_res = {sa, EMAX, {MAN_W{1'b0}}};
    else if (ib)
      sp_res = {sb, EMAX, {MAN_W{1'b0}}};
    else
      sp_hit = 1'b0;
  end

  logic s1_v, s1_sp, s1_inv, s1_s, s1_sub;
  logic [W-1:0] s1_spr;
  logic [EXP_W-1:0] s1_e, s1_d;
  logic [MW-1:0] s1_mb, s1_ms;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v <= 1'b0;
    end else if (adv) begin
      s1_v   <= bus.in_valid;
      s1_sp  <= sp_hit;
      s1_inv <= sp_inv;
      s1_spr <= sp_res;
      s1_sub <= sa ^ sb;
      if (a_big) begin
        s1_s  <= sa;
        s1_e  <= ea;
        s1_d  <= ea - eb;
        s1_mb <= {~za, fa_z};
        s1_ms <= {~zb, fb_z};
      end else begin
        s1_s  <= sb;
        s1_e  <= eb;
        s1_d  <= eb - ea;
        s1_mb <= {~zb, fb_z};
        s1_ms <= {~za, fa_z};
      end
    end
  end

  // ---------------- stage 2
  logic [AW-1:0] ext, shd, lost, al;
  logic [SW-1:0] sum;

  assign ext  = {s1_ms, 3'b000};
  assign shd  = ext >> s1_d;
  assign lost = ext & ~({AW{1'b1}} << s1_d);
  assign al   = {shd[AW-1:1], shd[0] | (|lost)};
  assign sum  = s1_sub ?
                {1'b0, s1_mb, 3'b000} - {1'b0, al} :
                {1'b0, s1_mb, 3'b000} + {1'b0, al};

  logic s2_v, s2_sp, s2_inv, s2_s, s2_sub;
  logic [W-1:0] s2_spr;
  logic [EXP_W-1:0] s2_e;
  logic [SW-1:0] s2_sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_v <= 1'b0;
    end else if (adv) begin
      s2_v   <= s1_v;
      s2_sp  <= s1_sp;
      s2_inv <= s1_inv;
      s2_spr <= s1_spr;
      s2_s   <= s1_s;
      s2_sub <= s1_sub;
      s2_e   <= s1_e;
      s2_sum <= sum;
    end
  end

  // ---------------- stage 3
  logic [LZW-1:0] lz;
  logic [SW-2:0] norm;
  logic signed [EW-1:0] e0, e1, e2, lzs;
  logic [MW-1:0] mant;
  logic [MAN_W-1:0] frac;
  logic g, r, st, inc, rc, nx;
  logic ovf, unf, zero;
  logic [W-1:0] res;
  logic [3:0] fl;

  always_comb begin
    lz = LZW'(AW);
    for (int i = 0; i < AW; i++)
      if (s2_sum[i]) lz = LZW'(AW - 1 - i);
  end

  assign e0  = $signed({{(EW-EXP_W){1'b0}}, s2_e});
  assign lzs = $signed({{(EW-LZW){1'b0}}, lz});

  // a carry out drops one bit, which must survive as sticky
  always_comb begin
    if (s2_sum[SW-1]) begin
      norm = {s2_sum[SW-1:2], |s2_sum[1:0]};
      e1   = e0 + EW'(1);
    end else begin
      norm = s2_sum[SW-2:0] << lz;
      e1   = e0 - lzs;
    end
  end

  assign mant = norm[SW-2:3];
  assign g    = norm[2];
  assign r    = norm[1];
  assign st   = norm[0];
  assign nx   = g | r | st;
  assign inc  = g & (r | st | mant[0]);
  assign rc   = inc & (&mant);
  assign frac = mant[MAN_W-1:0] + MAN_W'(inc);
  assign e2   = rc ? e1 + EW'(1) : e1;
  assign ovf  = (e2 >= EMX);
  assign unf  = e2[EW-1] | (e2 == '0);
  assign zero = ~|s2_sum;

  always_comb begin
    res = {s2_s, e2[EXP_W-1:0], frac};
    fl  = {3'b000, nx};
    if (s2_sp) begin
      res = s2_spr;
      fl  = {s2_inv, 3'b000};
    end else if (zero) begin
      res = {s2_s & ~s2_sub, {(W-1){1'b0}}};
      fl  = 4'b0000;
    end else if (ovf) begin
      res = {s2_s, EMAX, {MAN_W{1'b0}}};
      fl  = 4'b0101;
    end else if (unf) begin
      res = {s2_s, {(W-1){1'b0}}};
      fl  = 4'b0011;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_v <= 1'b0;
      out_r <= '0;
      out_f <= '0;
    end else if (adv) begin
      out_v <= s2_v;
      if (s2_v) begin
        out_r <= res;
        out_f <= fl;
      end
    end
  end
endmodule

// File: tb/tb_fp_add_pipe.sv
// Scoreboard bench: fp32 directed/stall/reset cases and a
// half-precision random sweep against an exact-sum model.
module tb_fp_add_pipe;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fp_add_pipe_if #(.EXP_W(8), .MAN_W(23)) f ();
  fp_add_pipe_if #(.EXP_W(5), .MAN_W(10)) h ();

  fp_add_pipe #(.EXP_W(8), .MAN_W(23)) u_f (
    .clk(clk), .reset(reset), .bus(f)
  );
  fp_add_pipe #(.EXP_W(5), .MAN_W(10)) u_h (
    .clk(clk), .reset(reset), .bus(h)
  );

  logic [35:0] q32[$];
  logic [19:0] qh[$];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] ref_h(
    input logic [15:0] a, b, input logic op);
    logic sa, sb, sg, nx;
    int ea, eb, emin, p, k, e;
    longint va, vb, sv, mag, q, rem, hf;
    sa = a[15];
    sb = b[15] ^ op;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    if ((ea == 31 && a[9:0] != 0) || (eb == 31 && b[9:0] != 0))
      return {4'b0000, 16'h7E00};
    if (ea == 31 && eb == 31)
      return (sa != sb) ? {4'b1000, 16'h7E00}
                        : {4'b0000, sa, 15'h7C00};
    if (ea == 31) return {4'b0000, sa, 15'h7C00};
    if (eb == 31) return {4'b0000, sb, 15'h7C00};
    if (ea == 0 && eb == 0) return {4'b0000, sa & sb, 15'h0};
    if (ea == 0) return {4'b0000, sb, b[14:0]};
    if (eb == 0) return {4'b0000, sa, a[14:0]};
    emin = (ea < eb) ? ea : eb;
    va = {53'd0, 1'b1, a[9:0]};
    vb = {53'd0, 1'b1, b[9:0]};
    va = va << (ea - emin);
    vb = vb << (eb - emin);
    sv = (sa ? -va : va) + (sb ? -vb : vb);
    if (sv == 0) return 20'h0;
    sg = (sv < 0);
    mag = sg ? -sv : sv;
    p = 0;
    for (int i = 0; i < 63; i++) if (mag[i]) p = i;
    e = emin + p - 10;
    nx = 1'b0;
    if (p > 10) begin
      k = p - 10;
      q = mag >> k;
      rem = mag & ((64'd1 << k) - 1);
      hf = 64'd1 << (k - 1);
      nx = (rem != 0);
      if (rem > hf || (rem == hf && q[0])) q = q + 1;
      if (q == 2048) begin
        q = q >> 1;
        e++;
      end
    end else begin
      q = mag << (10 - p);
    end
    if (e >= 31) return {4'b0101, sg, 15'h7C00};
    if (e <= 0) return {4'b0011, sg, 15'h0};
    return {3'b000, nx, sg, e[4:0], q[9:0]};
  endfunction

  always @(negedge clk) begin
    if (!reset && f.out_valid) begin
      if (f.out_ready) begin
        if (q32.size() == 0)
          chk("f_extra", 64'd1, 64'd0);
        else
          chk("f_res", 64'({f.out_flags, f.out_result}),
              64'(q32.pop_front()));
      end else begin
        chk("f_inrdy", 64'(f.in_ready), 64'd0);
        if (q32.size() != 0)
          chk("f_hold", 64'({f.out_flags, f.out_result}),
              64'(q32[0]));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && h.out_valid) begin
      if (h.out_ready) begin
        if (qh.size() == 0)
          chk("h_extra", 64'd1, 64'd0);
        else
          chk("h_res", 64'({h.out_flags, h.out_result}),
              64'(qh.pop_front()));
      end else if (qh.size() != 0) begin
        chk("h_hold", 64'({h.out_flags, h.out_result}),
            64'(qh[0]));
      end
    end
  end

  task automatic send_f(input logic [31:0] a, b,
                        input logic op,
                        input logic [35:0] e);
    bit ok;
    ok = 1'b0;
    f.in_a = a;
    f.in_b = b;
    f.in_op = op;
    f.in_valid = 1'b1;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (f.in_ready) begin
        q32.push_back(e);
        ok = 1'b1;
      end
    end
    chk("f_acc", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    f.in_valid = 1'b0;
  endtask

  task automatic send_h(input logic [15:0] a, b,
                        input logic op,
                        input logic [19:0] e);
    bit ok;
    ok = 1'b0;
    h.in_a = a;
    h.in_b = b;
    h.in_op = op;
    h.in_valid = 1'b1;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (h.in_ready) begin
        qh.push_back(e);
        ok = 1'b1;
      end
    end
    chk("h_acc", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    h.in_valid = 1'b0;
  endtask

  task automatic drain_f();
    for (int k = 0; k < 60 && q32.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("f_drain", 64'(q32.size()), 64'd0);
  endtask

  task automatic drain_h();
    for (int k = 0; k < 60 && qh.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("h_drain", 64'(qh.size()), 64'd0);
  endtask

  task automatic lat_f(input string tag);
    int n;
    n = 1;
    while (!f.out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, 64'(n), 64'd3);
  endtask

  task automatic rand_h();
    logic [15:0] a, b;
    a = 16'($urandom);
    b = 16'($urandom);
    if ($urandom_range(0, 1) == 1)
      b[14:10] = a[14:10] ^ 5'($urandom_range(0, 3));
    h.in_a = a;
    h.in_b = b;
    h.in_op = 1'($urandom_range(0, 1));
  endtask

  logic [31:0] s_a[6] = '{32'h3F800000, 32'h3F800000,
                          32'h40000000, 32'h40400000,
                          32'h3F000000, 32'h40800000};
  logic [31:0] s_b[6] = '{32'h3F800000, 32'h40000000,
                          32'h40000000, 32'h3F800000,
                          32'h3E800000, 32'h40800000};
  logic        s_o[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] s_e[6] = '{32'h40000000, 32'h40400000,
                          32'h40800000, 32'h40000000,
                          32'h3F400000, 32'h00000000};

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt, cyc;
    bit took;
    reset = 1'b1;
    f.in_valid = 1'b0;
    f.in_a = '0;
    f.in_b = '0;
    f.in_op = 1'b0;
    f.out_ready = 1'b1;
    h.in_valid = 1'b0;
    h.in_a = '0;
    h.in_b = '0;
    h.in_op = 1'b0;
    h.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    @(negedge clk);
    chk("rst_v", 64'(f.out_valid), 64'd0);
    chk("rst_res", 64'(f.out_result), 64'd0);
    chk("rst_fl", 64'(f.out_flags), 64'd0);
    chk("rst_rdy", 64'(f.in_ready), 64'd1);
    chk("rst_hv", 64'(h.out_valid), 64'd0);
    @(posedge clk);
    #1;

    send_f(32'h3F800000, 32'h40000000, 1'b0, {4'h0, 32'h40400000});
    lat_f("lat");
    drain_f();

    send_f(32'h3F800000, 32'h3F800000, 1'b1, {4'h0, 32'h00000000});
    send_f(32'h80000000, 32'h80000000, 1'b0, {4'h0, 32'h80000000});
    send_f(32'h3F800000, 32'h33800000, 1'b0, {4'h1, 32'h3F800000});
    send_f(32'h3F800001, 32'h33800000, 1'b0, {4'h1, 32'h3F800002});
    send_f(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, {4'h5, 32'h7F800000});
    send_f(32'h7F800000, 32'hFF800000, 1'b0, {4'h8, 32'h7FC00000});
    send_f(32'h7FC00001, 32'h3F800000, 1'b0, {4'h0, 32'h7FC00000});
    send_f(32'h7F800000, 32'h3F800000, 1'b1, {4'h0, 32'h7F800000});
    send_f(32'h40400000, 32'h80000000, 1'b0, {4'h0, 32'h40400000});
    send_f(32'h00000001, 32'h3F800000, 1'b0, {4'h0, 32'h3F800000});
    send_f(32'h00800001, 32'h00800000, 1'b1, {4'h3, 32'h00000000});
    send_f(32'h3F800000, 32'h40000000, 1'b1, {4'h0, 32'hBF800000});
    send_f(32'h3F800001, 32'h3F800000, 1'b1, {4'h0, 32'h34000000});
    drain_f();

    fork
      begin
        for (int i = 0; i < 6; i++)
          send_f(s_a[i], s_b[i], s_o[i], {4'h0, s_e[i]});
      end
      begin
        @(posedge clk);
        #1;
        f.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        f.out_ready = 1'b1;
      end
    join
    drain_f();

    send_f(32'h40000000, 32'h40000000, 1'b0, {4'h0, 32'h40800000});
    send_f(32'h3F800000, 32'h3F800000, 1'b0, {4'h0, 32'h40000000});
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q32.delete();
    chk("rst_mid", 64'(f.out_valid), 64'd0);
    send_f(32'h40400000, 32'h3F800000, 1'b0, {4'h0, 32'h40800000});
    lat_f("lat_rst");
    drain_f();

    send_h(16'h3C00, 16'h3C00, 1'b0, {4'h0, 16'h4000});
    send_h(16'h7BFF, 16'h7BFF, 1'b0, {4'h5, 16'h7C00});
    drain_h();

    cnt = 0;
    cyc = 0;
    rand_h();
    h.in_valid = 1'b1;
    while (cnt < 10000 && cyc < 40000) begin
      @(negedge clk);
      took = 1'b0;
      if (h.in_ready) begin
        qh.push_back(ref_h(h.in_a, h.in_b, h.in_op));
        cnt++;
        took = 1'b1;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (took) rand_h();
      h.out_ready = ($urandom_range(0, 3) != 0);
    end
    h.in_valid = 1'b0;
    h.out_ready = 1'b1;
    drain_h();
    chk("h_cnt", 64'(cnt), 64'd10000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
